// File: rtl/drink_vend_if.sv
// Coin-acceptor / dispenser signal bundle for the drink vending controller.
// The master drives the coin, cancel and restock requests; the slave (the controller) drives the vend/change status back.
interface drink_vend_if #(
    parameter int CREDIT_W = 4
);
    logic                half_i;
    logic                one_i;
    logic                cancel_i;
    logic                restock_i;
    logic                out_o;
    logic [1:0]          cout_o;
    logic                coin_rej_o;
    logic                sold_out_o;
    logic [CREDIT_W-1:0] credit_o;

    modport master (
        output half_i, one_i, cancel_i, restock_i,
        input  out_o, cout_o, coin_rej_o, sold_out_o, credit_o
    );

    modport slave (
        input  half_i, one_i, cancel_i, restock_i,
        output out_o, cout_o, coin_rej_o, sold_out_o, credit_o
    );
endinterface

// File: rtl/drink_vend_fsm.sv
// Parametrised drink vending controller: credit accumulation, vend strobe,
// serial change return, cancel/refund and stock tracking with restock.
//
// state     | meaning
// S_IDLE    | no credit held, waiting for first coin or restock
// S_COLLECT | partial credit held, waiting for more coins or cancel
// S_VEND    | vend strobe cycle, stock decremented on exit
// S_CHANGE  | returning change, one coin per cycle
module drink_vend_fsm #(
    parameter int PRICE      = 5,
    parameter int CREDIT_W   = 4,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    drink_vend_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic [STOCK_W-1:0]  stock_q, stock_d;
    logic                out_q, out_d;
    logic [1:0]          cout_q, cout_d;
    logic                sold_out_q, sold_out_d;

    logic [CREDIT_W-1:0] coin_v;
    logic [CREDIT_W-1:0] credit_n;
    logic                busy;
    logic                coin_ok;

    // Largest coin that fits in the remaining change (10 = one, 01 = half).
    function automatic logic [1:0] coin_of(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(2))      return 2'b10;
        else if (c == CREDIT_W'(1)) return 2'b01;
        else                        return 2'b00;
    endfunction

    assign coin_v   = {{(CREDIT_W-2){1'b0}}, bus.one_i, bus.half_i};
    assign credit_n = credit_q + coin_v;
    assign busy     = (state_q == S_VEND) || (state_q == S_CHANGE);
    assign coin_ok  = (coin_v != '0) && !busy && !sold_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            change_q   <= '0;
            stock_q    <= STOCK_W'(STOCK_INIT);
            out_q      <= 1'b0;
            cout_q     <= 2'b00;
            sold_out_q <= (STOCK_INIT == 0);
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            change_q   <= change_d;
            stock_q    <= stock_d;
            out_q      <= out_d;
            cout_q     <= cout_d;
            sold_out_q <= sold_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = change_q;
        stock_d  = stock_q;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                // A coin completing the price wins over a same-cycle cancel.
                if (coin_ok) begin
                    if (credit_n >= CREDIT_W'(PRICE)) begin
                        credit_d = '0;
                        change_d = credit_n - CREDIT_W'(PRICE);
                        state_d  = S_VEND;
                    end else if (bus.cancel_i && credit_q != '0) begin
                        credit_d = '0;
                        change_d = credit_n;
                        state_d  = S_CHANGE;
                    end else begin
                        credit_d = credit_n;
                        state_d  = S_COLLECT;
                    end
                end else if (bus.cancel_i && credit_q != '0) begin
                    credit_d = '0;
                    change_d = credit_q;
                    state_d  = S_CHANGE;
                end
                if (state_q == S_IDLE && bus.restock_i) begin
                    stock_d = STOCK_W'(STOCK_INIT);
                end
            end
            S_VEND: begin
                stock_d = stock_q - STOCK_W'(1);
                state_d = (change_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                change_d = change_q - {{(CREDIT_W-2){1'b0}}, coin_of(change_q)};
                state_d  = (change_d == '0) ? S_IDLE : S_CHANGE;
            end
            default: state_d = S_IDLE;
        endcase

        // Registered outputs are derived from the next state so they line up with it.
        out_d      = (state_d == S_VEND);
        cout_d     = (state_d == S_CHANGE) ? coin_of(change_d) : 2'b00;
        sold_out_d = (stock_d == '0);
    end

    assign bus.out_o      = out_q;
    assign bus.cout_o     = cout_q;
    assign bus.sold_out_o = sold_out_q;
    assign bus.credit_o   = credit_q;
    assign bus.coin_rej_o = (coin_v != '0) && (busy || sold_out_q);
endmodule

// File: tb/tb_drink_vend_fsm.sv
// Scoreboard bench for drink_vend_fsm: a queue-of-events reference model
// predicts each cycle's outputs; a negedge monitor compares them with the DUT.
module tb_drink_vend_fsm;
    localparam int PRICE      = 5;
    localparam int CREDIT_W   = 4;
    localparam int STOCK_W    = 4;
    localparam int STOCK_INIT = 2;

    localparam int H = 8, O = 4, C = 2, R = 1, N = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    drink_vend_if #(.CREDIT_W(CREDIT_W)) bus ();

    drink_vend_fsm #(
        .PRICE(PRICE), .CREDIT_W(CREDIT_W), .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       out;
        logic [1:0] cout;
        logic       rej;
        logic       sold;
        int         credit;
    } exp_t;

    typedef struct {
        logic       vend;
        logic [1:0] cout;
    } ev_t;

    exp_t exp_q[$];
    ev_t  pend[$];
    ev_t  cur;
    bit   cur_v;
    int   m_credit;
    int   m_stock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, expv, $time);
        end
    endtask

    // Outcome of a purchase or refund as a list of future cycles: optional vend, then coins largest first.
    task automatic schedule(input bit vend, input int ch);
        ev_t e;
        if (vend) begin
            e.vend = 1'b1; e.cout = 2'b00; pend.push_back(e);
        end
        while (ch >= 2) begin
            e.vend = 1'b0; e.cout = 2'b10; pend.push_back(e); ch -= 2;
        end
        if (ch == 1) begin
            e.vend = 1'b0; e.cout = 2'b01; pend.push_back(e);
        end
    endtask

    task automatic model_reset();
        m_credit = 0;
        m_stock  = STOCK_INIT;
        cur_v    = 1'b0;
        pend.delete();
    endtask

    task automatic step(input int code);
        bit   h, o, c, r, busy, idle;
        int   v, cn;
        exp_t e;
        h = code[3]; o = code[2]; c = code[1]; r = code[0];
        @(posedge clk);
        #1;
        bus.half_i = h; bus.one_i = o; bus.cancel_i = c; bus.restock_i = r;
        v    = int'(h) + 2 * int'(o);
        busy = cur_v;
        e.out    = cur_v && cur.vend;
        e.cout   = cur_v ? cur.cout : 2'b00;
        e.sold   = (m_stock == 0);
        e.credit = m_credit;
        e.rej    = (v != 0) && (busy || m_stock == 0);
        exp_q.push_back(e);

        if (cur_v && cur.vend) m_stock--;
        if (!busy) begin
            idle = (m_credit == 0);
            if (v != 0 && m_stock > 0) begin
                cn = m_credit + v;
                if (cn >= PRICE) begin
                    m_credit = 0; schedule(1'b1, cn - PRICE);
                end else if (c && m_credit != 0) begin
                    m_credit = 0; schedule(1'b0, cn);
                end else begin
                    m_credit = cn;
                end
            end else if (c && m_credit != 0) begin
                schedule(1'b0, m_credit); m_credit = 0;
            end
            if (idle && r) m_stock = STOCK_INIT;
        end
        cur_v = (pend.size() > 0);
        if (cur_v) cur = pend.pop_front();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out",      int'(bus.out_o),      int'(e.out));
            chk("cout",     int'(bus.cout_o),     int'(e.cout));
            chk("coin_rej", int'(bus.coin_rej_o), int'(e.rej));
            chk("sold_out", int'(bus.sold_out_o), int'(e.sold));
            chk("credit",   int'(bus.credit_o),   e.credit);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    int dir_seq[] = '{
        O, O, H, N, N, N, R, N,
        O, O, O, N, N, N, N, R, N,
        H|O, H|O, N, N, N, N, R, N,
        O, H, C, N, N, N, N,
        O, O, H, N, N, N, O, O, H, N, N, N,
        O, H, N, R, N, O, C, N, N, N,
        O, O, O, O, N, N, N, N, R, N
    };

    initial begin
        bus.half_i = 1'b0; bus.one_i = 1'b0; bus.cancel_i = 1'b0; bus.restock_i = 1'b0;
        model_reset();
        #3;
        chk("rst_out",      int'(bus.out_o),      0);
        chk("rst_cout",     int'(bus.cout_o),     0);
        chk("rst_coin_rej", int'(bus.coin_rej_o), 0);
        chk("rst_sold_out", int'(bus.sold_out_o), 0);
        chk("rst_credit",   int'(bus.credit_o),   0);
        #14;
        rst = 1'b0;

        foreach (dir_seq[i]) step(dir_seq[i]);

        // Reset while returning change of 2.
        step(O); step(C); step(N);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_cout",     int'(bus.cout_o),     0);
        chk("midrst_credit",   int'(bus.credit_o),   0);
        chk("midrst_out",      int'(bus.out_o),      0);
        chk("midrst_sold_out", int'(bus.sold_out_o), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        step(H); step(N); step(N);

        for (int i = 0; i < 3000; i++) begin
            int code;
            code = 0;
            if ($urandom_range(3) == 0) code |= H;
            if ($urandom_range(3) == 0) code |= O;
            if ($urandom_range(9) == 0) code |= C;
            if ($urandom_range(11) == 0) code |= R;
            step(code);
        end

        step(N); step(N);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
